// File: rtl/clk_period_meter_if.sv
// rtl/clk_period_meter_if.sv - signal, control and result bundle for clk_period_meter
interface clk_period_meter_if #(
  parameter int CNT_W    = 16,
  parameter int AVG_LOG2 = 3
);
  logic                      sig_in;
  logic                      clr;
  logic [CNT_W-1:0]          expect_period;
  logic [CNT_W-1:0]          tol;
  logic [CNT_W-1:0]          period;
  logic [CNT_W-1:0]          high_time;
  logic                      meas_valid;
  logic [CNT_W+AVG_LOG2-1:0] avg_sum;
  logic                      avg_valid;
  logic                      locked;
  logic                      period_err;
  logic                      timeout;

  modport master (
    output sig_in, clr, expect_period, tol,
    input  period, high_time, meas_valid, avg_sum, avg_valid, locked, period_err, timeout
  );

  modport slave (
    input  sig_in, clr, expect_period, tol,
    output period, high_time, meas_valid, avg_sum, avg_valid, locked, period_err, timeout
  );
endinterface

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - period / high-time meter with lock, mismatch and timeout flags
// Samples a periodic signal in the clk domain and publishes one measurement per rising edge.
module clk_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 3,
  parameter int TIMEOUT     = 1024,
  parameter int LOCK_CNT    = 4
) (
  input logic               clk,
  input logic               rstn,
  clk_period_meter_if.slave mon
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEAS = 2'd1;
  localparam logic [1:0] ST_TOUT = 2'd2;

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int ACC_W   = CNT_W + AVG_LOG2;

  localparam logic [CNT_W-1:0]    TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MATCH_W-1:0]  LOCK_C    = MATCH_W'(LOCK_CNT);
  localparam logic [AVG_LOG2-1:0] WIN_LAST  = '1;
  localparam logic [CNT_W-1:0]    ONE_C     = CNT_W'(1);

  logic sync_out;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_out = mon.sig_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= mon.sig_in;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign sync_out = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // clr deliberately leaves s_q/sd_q alone so the edge history survives a clear
  logic s_q, sd_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_q  <= 1'b0;
      sd_q <= 1'b0;
    end else begin
      s_q  <= sync_out;
      sd_q <= s_q;
    end
  end

  logic rise, fall;
  assign rise = s_q & ~sd_q;
  assign fall = ~s_q & sd_q;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    hcnt_q, hcnt_d;
  logic [CNT_W-1:0]    hi_pend_q, hi_pend_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [CNT_W-1:0]    high_time_q, high_time_d;
  logic                meas_valid_q, meas_valid_d;
  logic [ACC_W-1:0]    avg_sum_q, avg_sum_d;
  logic                avg_valid_q, avg_valid_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [AVG_LOG2-1:0] win_q, win_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic                locked_q, locked_d;
  logic                period_err_q, period_err_d;
  logic                timeout_q, timeout_d;

  // cnt_q is the period being closed whenever rise is high in MEAS
  logic [CNT_W-1:0] diff;
  logic             in_tol;
  logic [ACC_W-1:0] acc_sum;
  assign diff    = (cnt_q >= mon.expect_period) ? cnt_q - mon.expect_period
                                                : mon.expect_period - cnt_q;
  assign in_tol  = (diff <= mon.tol);
  assign acc_sum = acc_q + ACC_W'(cnt_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hcnt_d       = hcnt_q;
    hi_pend_d    = hi_pend_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    avg_sum_d    = avg_sum_q;
    avg_valid_d  = 1'b0;
    acc_d        = acc_q;
    win_d        = win_q;
    match_d      = match_q;
    locked_d     = locked_q;
    period_err_d = 1'b0;
    timeout_d    = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEAS;
          cnt_d   = ONE_C;
          hcnt_d  = ONE_C;
        end
      end
      ST_MEAS: begin
        if (rise) begin
          cnt_d        = ONE_C;
          hcnt_d       = ONE_C;
          period_d     = cnt_q;
          high_time_d  = hi_pend_q;
          meas_valid_d = 1'b1;
          if (win_q == WIN_LAST) begin
            avg_sum_d   = acc_sum;
            avg_valid_d = 1'b1;
            acc_d       = '0;
            win_d       = '0;
          end else begin
            acc_d = acc_sum;
            win_d = win_q + 1'b1;
          end
          if (mon.expect_period == '0) begin
            match_d  = '0;
            locked_d = 1'b0;
          end else if (in_tol) begin
            match_d  = (match_q == LOCK_C) ? match_q : match_q + 1'b1;
            locked_d = (match_d == LOCK_C);
          end else begin
            period_err_d = 1'b1;
            match_d      = '0;
            locked_d     = 1'b0;
          end
        end else if (cnt_q == TIMEOUT_C) begin
          state_d   = ST_TOUT;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
          acc_d     = '0;
          win_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (s_q) hcnt_d = hcnt_q + 1'b1;
          if (fall) hi_pend_d = hcnt_q;
        end
      end
      ST_TOUT: begin
        if (rise) begin
          state_d   = ST_MEAS;
          timeout_d = 1'b0;
          cnt_d     = ONE_C;
          hcnt_d    = ONE_C;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (mon.clr) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      hcnt_d       = '0;
      hi_pend_d    = '0;
      period_d     = '0;
      high_time_d  = '0;
      meas_valid_d = 1'b0;
      avg_sum_d    = '0;
      avg_valid_d  = 1'b0;
      acc_d        = '0;
      win_d        = '0;
      match_d      = '0;
      locked_d     = 1'b0;
      period_err_d = 1'b0;
      timeout_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      hi_pend_q    <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      avg_sum_q    <= '0;
      avg_valid_q  <= 1'b0;
      acc_q        <= '0;
      win_q        <= '0;
      match_q      <= '0;
      locked_q     <= 1'b0;
      period_err_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      hi_pend_q    <= hi_pend_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      avg_sum_q    <= avg_sum_d;
      avg_valid_q  <= avg_valid_d;
      acc_q        <= acc_d;
      win_q        <= win_d;
      match_q      <= match_d;
      locked_q     <= locked_d;
      period_err_q <= period_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign mon.period     = period_q;
  assign mon.high_time  = high_time_q;
  assign mon.meas_valid = meas_valid_q;
  assign mon.avg_sum    = avg_sum_q;
  assign mon.avg_valid  = avg_valid_q;
  assign mon.locked     = locked_q;
  assign mon.period_err = period_err_q;
  assign mon.timeout    = timeout_q;
endmodule
